// File: rtl/cpm_rq_rr_arbiter.sv
// Packet-level round-robin arbiter sharing the CPM RQ AXI-Stream port between the
// H2C read engine (port 0) and the C2H write engine (port 1), with a 2-entry output buffer.

module cpm_rq_rr_arbiter #(
   parameter int DATA_W = 512,
   parameter int USER_W = 137,
   parameter int KEEP_W = 16
) (
   input  logic              user_clk,
   input  logic              user_reset,
   input  logic [DATA_W-1:0] s0_axis_rq_tdata,
   input  logic [USER_W-1:0] s0_axis_rq_tuser,
   input  logic [KEEP_W-1:0] s0_axis_rq_tkeep,
   input  logic              s0_axis_rq_tlast,
   input  logic              s0_axis_rq_tvalid,
   output logic              s0_axis_rq_tready,
   input  logic [DATA_W-1:0] s1_axis_rq_tdata,
   input  logic [USER_W-1:0] s1_axis_rq_tuser,
   input  logic [KEEP_W-1:0] s1_axis_rq_tkeep,
   input  logic              s1_axis_rq_tlast,
   input  logic              s1_axis_rq_tvalid,
   output logic              s1_axis_rq_tready,
   output logic [DATA_W-1:0] m_axis_rq_tdata,
   output logic [USER_W-1:0] m_axis_rq_tuser,
   output logic [KEEP_W-1:0] m_axis_rq_tkeep,
   output logic              m_axis_rq_tlast,
   output logic              m_axis_rq_tvalid,
   input  logic [3:0]        m_axis_rq_tready,
   output logic [1:0]        arb_grant,
   output logic              arb_in_pkt
);

   localparam int ENTRY_W = DATA_W + USER_W + KEEP_W + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic               last_gnt_r;
   logic               last_gnt_s;
   logic               in_pkt_r;
   logic               in_pkt_s;
   logic [1:0]         count_r;
   logic               rd_ptr_r;
   logic               wr_ptr_r;
   logic [ENTRY_W-1:0] mem_r [2];
   logic               buf_ready_s;
   logic               push_s;
   logic               pop_s;
   logic [ENTRY_W-1:0] push_data_s;
   logic               unused_tready_s;

   // Only copy 0 of the replicated CPM ready is meaningful.
   assign unused_tready_s = ^m_axis_rq_tready[3:1];

   // Ready is derived from the registered count only, so m_axis_rq_tready never reaches s*_tready.
   assign buf_ready_s      = (count_r < 2'd2);
   assign pop_s            = (count_r != 2'd0) && m_axis_rq_tready[0];
   assign m_axis_rq_tvalid = (count_r != 2'd0);
   assign {m_axis_rq_tdata, m_axis_rq_tuser, m_axis_rq_tkeep, m_axis_rq_tlast} = mem_r[rd_ptr_r];
   assign arb_in_pkt       = in_pkt_r;

   // Arbitration next-state, requester readies and buffer push selection.
   always_comb begin
      state_s           = state_r;
      last_gnt_s        = last_gnt_r;
      in_pkt_s          = in_pkt_r;
      s0_axis_rq_tready = 1'b0;
      s1_axis_rq_tready = 1'b0;
      arb_grant         = 2'b00;
      push_s            = 1'b0;
      push_data_s       = {s0_axis_rq_tdata, s0_axis_rq_tuser, s0_axis_rq_tkeep, s0_axis_rq_tlast};
      case (state_r)
         IDLE: begin
            if (s0_axis_rq_tvalid && s1_axis_rq_tvalid) begin
               state_s = last_gnt_r ? GNT0 : GNT1;
            end else if (s0_axis_rq_tvalid) begin
               state_s = GNT0;
            end else if (s1_axis_rq_tvalid) begin
               state_s = GNT1;
            end else begin
               state_s = IDLE;
            end
         end
         GNT0: begin
            arb_grant         = 2'b01;
            s0_axis_rq_tready = buf_ready_s;
            push_s            = s0_axis_rq_tvalid && buf_ready_s;
            if (push_s && s0_axis_rq_tlast) begin
               in_pkt_s   = 1'b0;
               last_gnt_s = 1'b0;
               if (s1_axis_rq_tvalid) begin
                  state_s = GNT1;
               end else if (s0_axis_rq_tvalid) begin
                  state_s = GNT0;
               end else begin
                  state_s = IDLE;
               end
            end else if (push_s) begin
               in_pkt_s = 1'b1;
            end else if (!in_pkt_r && !s0_axis_rq_tvalid) begin
               // Between packets the held grant is released once the requester goes quiet.
               state_s = s1_axis_rq_tvalid ? GNT1 : IDLE;
            end else begin
               state_s = GNT0;
            end
         end
         GNT1: begin
            arb_grant         = 2'b10;
            s1_axis_rq_tready = buf_ready_s;
            push_s            = s1_axis_rq_tvalid && buf_ready_s;
            push_data_s       = {s1_axis_rq_tdata, s1_axis_rq_tuser, s1_axis_rq_tkeep, s1_axis_rq_tlast};
            if (push_s && s1_axis_rq_tlast) begin
               in_pkt_s   = 1'b0;
               last_gnt_s = 1'b1;
               if (s0_axis_rq_tvalid) begin
                  state_s = GNT0;
               end else if (s1_axis_rq_tvalid) begin
                  state_s = GNT1;
               end else begin
                  state_s = IDLE;
               end
            end else if (push_s) begin
               in_pkt_s = 1'b1;
            end else if (!in_pkt_r && !s1_axis_rq_tvalid) begin
               state_s = s0_axis_rq_tvalid ? GNT0 : IDLE;
            end else begin
               state_s = GNT1;
            end
         end
         default: begin
            state_s  = IDLE;
            in_pkt_s = 1'b0;
         end
      endcase
   end

   // Arbiter state registers.
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         state_r    <= IDLE;
         last_gnt_r <= 1'b1;
         in_pkt_r   <= 1'b0;
      end else begin
         state_r    <= state_s;
         last_gnt_r <= last_gnt_s;
         in_pkt_r   <= in_pkt_s;
      end
   end

   // Output buffer occupancy and pointers.
   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         count_r  <= 2'd0;
         rd_ptr_r <= 1'b0;
         wr_ptr_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Output buffer storage; contents are don't-care until counted valid.
   always_ff @(posedge user_clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= push_data_s;
      end
   end

endmodule
